// File: rtl/vec_unscale.sv
// Sequential signed Q16.16 vector-by-scalar divider: out_i = (x_i << FRAC) / a.
// One radix-2 restoring divider is shared over the three components.
module vec_unscale #(
  parameter int FRAC = 16,
  parameter int ITER = 32 + FRAC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [95:0] x,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [95:0] out,
  output logic        div_zero
);

  localparam int DW = 32 + FRAC;
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd;
  logic [32:0]   rem;
  logic [31:0]   amag;
  logic          a_zero;
  logic [31:0]   mag [3];
  logic [2:0]    xneg;
  logic [2:0]    neg;

  // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  logic [32:0] rem_sh;
  logic [32:0] rem_nxt;
  logic        qbit;
  logic [1:0]  nxt;
  logic [31:0] res;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rem_sh  = {rem[31:0], dvd[DW-1]};
    qbit    = 1'b0;
    rem_nxt = rem_sh;
    if (rem_sh >= {1'b0, amag}) begin
      qbit    = 1'b1;
      rem_nxt = rem_sh - {1'b0, amag};
    end
  end

  // Sign, saturation and divide-by-zero override for the finished component.
  always_comb begin
    nxt = idx + 2'd1;
    res = '0;
    if (a_zero) begin
      if (mag[idx] != 32'd0) res = xneg[idx] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (neg[idx]) begin
      res = (dvd > DW'(33'h0_8000_0000)) ? 32'h8000_0000 : (~dvd[31:0] + 32'd1);
    end else begin
      res = (dvd > DW'(32'h7FFF_FFFF)) ? 32'h7FFF_FFFF : dvd[31:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the small
  // magnitude array is reset too so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      div_zero  <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      dvd       <= '0;
      rem       <= '0;
      amag      <= '0;
      a_zero    <= 1'b0;
      xneg      <= '0;
      neg       <= '0;
      for (int i = 0; i < 3; i++) mag[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            amag   <= mag32(a);
            a_zero <= (a == 32'd0);
            for (int i = 0; i < 3; i++) begin
              mag[i]  <= mag32(x[i*32 +: 32]);
              xneg[i] <= x[i*32 + 31];
              neg[i]  <= x[i*32 + 31] ^ a[31];
            end
            idx      <= '0;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= {mag32(x[31:0]), {FRAC{1'b0}}};
            in_ready <= 1'b0;
            state    <= DIV;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          dvd <= {dvd[DW-2:0], qbit};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= FIX;
        end
        FIX: begin
          out[idx*32 +: 32] <= res;
          div_zero          <= a_zero;
          if (idx != 2'd2) begin
            idx   <= nxt;
            cnt   <= '0;
            rem   <= '0;
            dvd   <= {mag[nxt], {FRAC{1'b0}}};
            state <= DIV;
          end else begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_unscale.sv
// Directed self-checking bench for vec_unscale with hand-computed Q16.16 quotients.
module tb_vec_unscale;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] x;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out;
  logic        div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vec_unscale dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .a(a), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .div_zero(div_zero)
  );

  // Issue one operation from IDLE; report cycles to out_valid (-1 on timeout)
  // and whether in_ready/out_valid stayed low while busy.
  task automatic start_op(input logic [95:0] vx, input logic [31:0] va,
                          output int lat, output bit busy_ok);
    busy_ok  = 1'b1;
    lat      = -1;
    x        = vx;
    a        = va;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; a = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 96'd0 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out=%h div_zero=%b, want 1 0 0 0",
               in_ready, out_valid, out, div_zero);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int lat; bit busy;
    start_op({32'hFFFD_0000, 32'h0002_0000, 32'h0001_0000}, 32'h0002_0000, lat, busy);
    n_checks++;
    if (lat !== 147) begin n_fail++; $display("FAIL basic_latency: got %0d want 147", lat); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: in_ready/out_valid high while busy got %b want 1", busy); end
    n_checks++;
    if (out !== {32'hFFFE_8000, 32'h0001_0000, 32'h0000_8000}) begin
      n_fail++; $display("FAIL basic_out: got %h want %h", out, {32'hFFFE_8000, 32'h0001_0000, 32'h0000_8000});
    end
    n_checks++;
    if (div_zero !== 1'b0) begin n_fail++; $display("FAIL basic_div_zero: got %b want 0", div_zero); end
    finish_op();
  endtask

  task automatic test_truncation();
    int lat; bit busy;
    start_op({32'h0000_0000, 32'hFFFF_0000, 32'h0001_0000}, 32'h0003_0000, lat, busy);
    n_checks++;
    if (lat !== 147 || out !== {32'h0000_0000, 32'hFFFF_AAAB, 32'h0000_5555}) begin
      n_fail++; $display("FAIL trunc_out: got %h lat %0d want %h lat 147",
                         out, lat, {32'h0000_0000, 32'hFFFF_AAAB, 32'h0000_5555});
    end
    finish_op();
  endtask

  task automatic test_div_zero();
    int lat; bit busy;
    start_op({32'hFFFF_0000, 32'h0000_0000, 32'h0001_0000}, 32'h0000_0000, lat, busy);
    n_checks++;
    if (lat !== 147) begin n_fail++; $display("FAIL dz_latency: got %0d want 147", lat); end
    n_checks++;
    if (out !== {32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF}) begin
      n_fail++; $display("FAIL dz_out: got %h want %h", out, {32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF});
    end
    n_checks++;
    if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", div_zero); end
    finish_op();
  endtask

  task automatic test_saturation();
    int lat; bit busy;
    start_op({32'h0000_0100, 32'h8000_0000, 32'h7FFF_FFFF}, 32'h0000_0100, lat, busy);
    n_checks++;
    if (out !== {32'h0001_0000, 32'h8000_0000, 32'h7FFF_FFFF}) begin
      n_fail++; $display("FAIL sat_out: got %h want %h", out, {32'h0001_0000, 32'h8000_0000, 32'h7FFF_FFFF});
    end
    finish_op();
    start_op({32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF}, 32'hFFFF_FF00, lat, busy);
    n_checks++;
    if (out !== {32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000} || div_zero !== 1'b0) begin
      n_fail++; $display("FAIL sat_neg_div: got %h dz %b want %h dz 0",
                         out, div_zero, {32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    end
    finish_op();
  endtask

  task automatic test_min_divisor();
    int lat; bit busy;
    start_op({32'h0001_0000, 32'hC000_0000, 32'h4000_0000}, 32'h8000_0000, lat, busy);
    n_checks++;
    if (out !== {32'hFFFF_FFFE, 32'h0000_8000, 32'hFFFF_8000}) begin
      n_fail++; $display("FAIL min_divisor_out: got %h want %h", out, {32'hFFFF_FFFE, 32'h0000_8000, 32'hFFFF_8000});
    end
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat; bit busy;
    logic [95:0] held;
    start_op({32'hFFFD_0000, 32'h0002_0000, 32'h0001_0000}, 32'h0002_0000, lat, busy);
    held = {32'hFFFE_8000, 32'h0001_0000, 32'h0000_8000};
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        x = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        a = 32'h0001_0000;
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== held) begin
        n_fail++; $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out=%h want 1 0 %h",
                           i, out_valid, in_ready, out, held);
      end
    end
    finish_op();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== held) begin
      n_fail++; $display("FAIL bp_release: out_valid=%b in_ready=%b out=%h want 0 1 %h",
                         out_valid, in_ready, out, held);
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_ignored_pulse: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit busy;
    start_op({32'h0000_0000, 32'hFFFF_0000, 32'h0001_0000}, 32'h0003_0000, lat, busy);
    finish_op();
    start_op({32'hFFFF_0000, 32'h0000_0000, 32'h0001_0000}, 32'h0000_0000, lat, busy);
    n_checks++;
    if (lat !== 147 || out !== {32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF} || div_zero !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: got %h dz %b lat %0d want %h dz 1 lat 147",
                         out, div_zero, lat, {32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF});
    end
    finish_op();
  endtask

  task automatic test_reset_mid_op();
    int lat; bit busy;
    x = {32'h0000_0100, 32'h8000_0000, 32'h7FFF_FFFF};
    a = 32'h0000_0100;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out !== 96'd0 || in_ready !== 1'b1 || div_zero !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state: out_valid=%b out=%h in_ready=%b dz=%b want 0 0 1 0",
                         out_valid, out, in_ready, div_zero);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    start_op({32'hFFFD_0000, 32'h0002_0000, 32'h0001_0000}, 32'h0002_0000, lat, busy);
    n_checks++;
    if (lat !== 147 || out !== {32'hFFFE_8000, 32'h0001_0000, 32'h0000_8000}) begin
      n_fail++; $display("FAIL midreset_fresh: got %h lat %0d want %h lat 147",
                         out, lat, {32'hFFFE_8000, 32'h0001_0000, 32'h0000_8000});
    end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncation();
    test_div_zero();
    test_saturation();
    test_min_divisor();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
